sample_playback_ctrl: RTL
=========================

// Module: sample_playback_ctrl
// PURPOSE
//   Sequencer for the audio sample ROM. On start, fetches ROM words from start_addr to end_addr at one
//   sample per (rate_div+1) clocks, with optional looping. Holds the current sample for the pdm modulator
//   (sample_out -> pdm_in). Replaces the free-running counter-indexed ROM lookup with controlled playback.
// PARAMETERS
//   ADDR_W  8   ROM address width; address arithmetic wraps modulo 2^ADDR_W
//   DATA_W  8   ROM word / sample width
//   DIV_W   11  rate divider width
// PORTS
//   clk          in   1       system clock (same clock as pdm and hvsync_generator)
//   reset        in   1       synchronous, active-high reset
//   start        in   1       1-cycle pulse: begin playback (sampled only in IDLE)
//   stop         in   1       1-cycle pulse: abort playback, any state
//   loop_en      in   1       1 = restart at start_addr after end_addr; latched on start
//   start_addr   in   ADDR_W  first ROM address; latched on start
//   end_addr     in   ADDR_W  last ROM address, inclusive; latched on start
//   rate_div     in   DIV_W   sample period minus 1, in clocks; latched on start
//   rom_req      out  1       ROM read request; held high until rom_ack
//   rom_addr     out  ADDR_W  ROM address; stable while rom_req=1
//   rom_ack      in   1       ROM data valid this cycle; may be high in the same cycle as rom_req
//   rom_data     in   DATA_W  ROM word; sampled only when rom_req & rom_ack
//   sample_out   out  DATA_W  current sample, registered; 0 when idle
//   sample_valid out  1       1-cycle pulse in the first cycle sample_out holds a new value
//   busy         out  1       high in every non-IDLE state
//   done         out  1       1-cycle pulse when non-looping playback completes
//   underrun     out  1       sticky: a sample tick arrived while a fetch was still pending
// BEHAVIOUR
//   Reset: state=IDLE; rom_req, rom_addr, sample_out, sample_valid, busy, done, underrun all 0.
//   States: IDLE, REQ, HOLD.
//   IDLE: start & !stop -> latch config, addr<=start_addr, cnt<=rate_div, underrun<=0, go REQ.
//   REQ: rom_req=1, rom_addr=addr. On rom_ack: sample_out<=rom_data, sample_valid<=1, go HOLD.
//   HOLD: wait for tick. On tick:
//     - addr!=end_addr: addr<=addr+1 (0xFF->0x00 wraps), go REQ.
//     - addr==end_addr & loop_en: addr<=start_addr, go REQ.
//     - addr==end_addr & !loop_en: go IDLE; next cycle sample_out=0, busy=0, done=1.
//   Divider: while busy, cnt decrements every cycle. tick = (cnt==0), then cnt reloads rate_div.
//     Period is exactly rate_div+1 clocks, independent of ROM latency.
//   Timing, start pulse in cycle 0, zero-wait ROM (ack=req): rom_req high in cycle 1.
//     Sample k is valid from cycle 2+k*(rate_div+1). Ticks occur at cycles 1+rate_div+k*(rate_div+1).
//   Tick while in REQ: underrun<=1. Tick is consumed, not queued. Fetch completes normally;
//     the address advances on the next tick seen in HOLD. Legal use requires rate_div >= 1 + ROM wait cycles.
//   end_addr < start_addr: playback walks through 2^ADDR_W-1, wraps to 0, continues to end_addr.
//   start_addr == end_addr: single sample, repeated if loop_en=1.
//   stop (any state): go IDLE next cycle. rom_req=0, sample_out=0, busy=0. No done pulse.
//     Pending fetch is abandoned. stop wins over start in the same cycle.
//   start while busy: ignored; latched config is unchanged.
//   reset mid-playback: identical to power-on reset, next cycle.
// TESTING
//   T1: start=0x10,end=0x13,loop=0,rate_div=3, ROM data=addr, ack=req.
//       sample_out = 10,11,12,13 at cycles 2,6,10,14. done=1, busy=0, sample_out=0 at cycle 17.
//   T2: T1 with loop_en=1 -> sample_out 0x10 again at cycle 18, 0x11 at 22; busy stays 1; no done.
//   T3: start=0xFE,end=0x01,rate_div=3 -> rom_addr sequence FE,FF,00,01; done after 4 samples.
//   T4: rate_div=3, ack delayed 5 cycles after req -> underrun=1 by cycle 5; sample 0 still delivered.
//       Next start clears underrun.
//   T5: stop while in REQ (ack held low) -> next cycle rom_req=0, busy=0, sample_out=0, done=0.
//       start+stop same cycle from IDLE -> busy stays 0.
//   T6: reset asserted mid-playback at a sample_valid cycle -> next cycle all outputs 0, state IDLE.
//       start after reset plays from start_addr.

Source files
------------

// File: rtl/sample_playback_ctrl.sv
// Audio sample ROM sequencer: walks start_addr..end_addr at one sample per
// (rate_div+1) clocks, optionally looping, and holds the sample for the modulator.
module sample_playback_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DIV_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DIV_W-1:0]  rate_div,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [DIV_W-1:0]  CNT_ONE  = 1;

  state_t r_state, w_next;

  logic [ADDR_W-1:0] r_addr, r_start_addr, r_end_addr;
  logic [DIV_W-1:0]  r_div, r_cnt;
  logic              r_loop;
  logic [DATA_W-1:0] r_sample;
  logic              r_valid, r_done, r_underrun;

  logic w_tick, w_last;

  // The divider free-runs from the start pulse, so the period never depends on ROM latency.
  assign w_tick = (r_state != IDLE) && (r_cnt == '0);
  assign w_last = (r_addr == r_end_addr);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (stop) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start)   w_next = REQ;
        REQ:     if (rom_ack) w_next = HOLD;
        HOLD:    if (w_tick)  w_next = (w_last && !r_loop) ? IDLE : REQ;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr       <= '0;
      r_start_addr <= '0;
      r_end_addr   <= '0;
      r_div        <= '0;
      r_cnt        <= '0;
      r_loop       <= 1'b0;
      r_sample     <= '0;
      r_valid      <= 1'b0;
      r_done       <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      if (stop) begin
        r_sample <= '0;
      end else begin
        if (r_state != IDLE) r_cnt <= w_tick ? r_div : r_cnt - CNT_ONE;
        case (r_state)
          IDLE: begin
            if (start) begin
              r_start_addr <= start_addr;
              r_end_addr   <= end_addr;
              r_loop       <= loop_en;
              r_div        <= rate_div;
              r_addr       <= start_addr;
              r_cnt        <= rate_div;
              r_underrun   <= 1'b0;
            end
          end
          REQ: begin
            if (rom_ack) begin
              r_sample <= rom_data;
              r_valid  <= 1'b1;
            end
            // A tick during a pending fetch is dropped; the address advances on the next one.
            if (w_tick) r_underrun <= 1'b1;
          end
          HOLD: begin
            if (w_tick) begin
              if (!w_last)     r_addr <= r_addr + ADDR_ONE;
              else if (r_loop) r_addr <= r_start_addr;
              else begin
                r_sample <= '0;
                r_done   <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rom_req      = (r_state == REQ);
  assign rom_addr     = r_addr;
  assign sample_out   = r_sample;
  assign sample_valid = r_valid;
  assign busy         = (r_state != IDLE);
  assign done         = r_done;
  assign underrun     = r_underrun;

endmodule
